uart_receiver: RTL and testbench

Serial receive stage fed by the baud generator's `baudRateX16Tick`. It oversamples the asynchronous `rxd` line at 16× the baud rate and recovers start/data/parity/stop bits with 3-sample majority voting. It presents each received character through a one-entry valid/ready holding register with per-character error flags, for the bus-side UART register block.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_rx_sampler.sv | 48 ++++
 rtl/uart_receiver.sv | 179 +++++++++++++++++
 tb/tb_uart_receiver.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, data-width encoding,
// oversampling phase constants and small bit-level helpers.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP1  = 3'd4,
      ST_STOP2  = 3'd5
   } rxState_t;

   typedef enum logic [1:0] {
      BITS_5 = 2'b00,
      BITS_6 = 2'b01,
      BITS_7 = 2'b10,
      BITS_8 = 2'b11
   } dataBits_t;

   localparam logic [3:0] SAMPLE_A   = 4'd7;
   localparam logic [3:0] SAMPLE_B   = 4'd8;
   localparam logic [3:0] SAMPLE_C   = 4'd9;
   localparam logic [3:0] PHASE_LAST = 4'd15;

   function automatic logic majority3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   // Index of the final data bit: selection + 4, i.e. 4..7.
   function automatic logic [2:0] lastBitIdx(input dataBits_t sel);
      return {1'b1, sel};
   endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Front end of the receiver: 2-flop synchronizer, previous-sample tracker for
// start-edge detection, and the 3-sample majority voter around mid-bit.
module uart_rx_sampler
   import uart_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       baudRateX16Tick,
   input  logic       rxd,
   input  logic [3:0] phase,
   output logic       rxdS,
   output logic       prevS,
   output logic       bitDecision
);

   logic rxdMeta_p0;
   logic sampleA;
   logic sampleB;

   // Stage p0 -> rxdS: metastability filter on the asynchronous line
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxdMeta_p0 <= 1'b1;
         rxdS       <= 1'b1;
      end else begin
         rxdMeta_p0 <= rxd;
         rxdS       <= rxdMeta_p0;
      end
   end

   // prevS follows the line on every tick, so a frame that ends with the line
   // held low leaves prevS=0 and a break cannot re-trigger a start.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         prevS   <= 1'b1;
         sampleA <= 1'b1;
         sampleB <= 1'b1;
      end else if (baudRateX16Tick) begin
         prevS <= rxdS;
         if (phase == SAMPLE_A) sampleA <= rxdS;
         if (phase == SAMPLE_B) sampleB <= rxdS;
      end
   end

   // The third vote is the live sample on the phase-9 tick.
   assign bitDecision = majority3(sampleA, sampleB, rxdS);

endmodule

// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled frame FSM, data/parity capture and a
// one-entry valid/ready holding register with per-character error flags.
module uart_receiver
   import uart_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       baudRateX16Tick,
   input  logic       rxd,
   input  logic [1:0] dataBitsSel,
   input  logic       parityEnable,
   input  logic       parityOdd,
   input  logic       stopBits2,
   input  logic       rxReady,
   output logic [7:0] rxData,
   output logic       rxValid,
   output logic       framingError,
   output logic       parityError,
   output logic       breakDetect,
   output logic       overrun
);

   rxState_t  state;
   logic [3:0] phase;
   logic [2:0] bitIdx;
   dataBits_t frmBits;
   logic      frmParEn;
   logic      frmParOdd;
   logic      frmStop2;

   logic [7:0] dataReg;
   logic       parAcc;
   logic       parBitReg;
   logic       parErrReg;
   logic       stop1Reg;

   logic rxdS;
   logic prevS;
   logic bitDecision;

   logic startEdge;
   logic sampleTick;
   logic bitEndTick;
   logic complete;
   logic firstStop;
   logic newFraming;
   logic newBreak;

   uart_rx_sampler sampler (
      .clock           (clock),
      .reset           (reset),
      .baudRateX16Tick (baudRateX16Tick),
      .rxd             (rxd),
      .phase           (phase),
      .rxdS            (rxdS),
      .prevS           (prevS),
      .bitDecision     (bitDecision)
   );

   assign startEdge  = baudRateX16Tick && (state == ST_IDLE) && prevS && !rxdS;
   assign sampleTick = baudRateX16Tick && (phase == SAMPLE_C);
   assign bitEndTick = baudRateX16Tick && (phase == PHASE_LAST);
   assign complete   = sampleTick &&
                       (((state == ST_STOP1) && !frmStop2) || (state == ST_STOP2));

   assign firstStop  = (state == ST_STOP2) ? stop1Reg : bitDecision;
   assign newFraming = !firstStop || ((state == ST_STOP2) && !bitDecision);
   assign newBreak   = (dataReg == 8'd0) && !(frmParEn && parBitReg) && !firstStop;

   // Frame control: state, bit timing and the per-frame format snapshot
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         phase     <= 4'd0;
         bitIdx    <= 3'd0;
         frmBits   <= BITS_8;
         frmParEn  <= 1'b0;
         frmParOdd <= 1'b0;
         frmStop2  <= 1'b0;
      end else if (baudRateX16Tick) begin
         phase <= phase + 4'd1;
         case (state)
            ST_IDLE: begin
               if (startEdge) begin
                  state     <= ST_START;
                  phase     <= 4'd0;
                  frmBits   <= dataBits_t'(dataBitsSel);
                  frmParEn  <= parityEnable;
                  frmParOdd <= parityOdd;
                  frmStop2  <= stopBits2;
               end
            end
            ST_START: begin
               if (sampleTick && bitDecision) begin
                  state <= ST_IDLE;
               end else if (bitEndTick) begin
                  state  <= ST_DATA;
                  bitIdx <= 3'd0;
               end
            end
            ST_DATA: begin
               if (bitEndTick) begin
                  if (bitIdx == lastBitIdx(frmBits)) begin
                     state <= frmParEn ? ST_PARITY : ST_STOP1;
                  end else begin
                     bitIdx <= bitIdx + 3'd1;
                  end
               end
            end
            ST_PARITY: begin
               if (bitEndTick) state <= ST_STOP1;
            end
            ST_STOP1: begin
               if (sampleTick && !frmStop2) begin
                  state <= ST_IDLE;
               end else if (bitEndTick) begin
                  state <= ST_STOP2;
               end
            end
            ST_STOP2: begin
               if (sampleTick) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // Character capture: cleared at each start edge, filled at the phase-9 decisions
   always_ff @(posedge clock) begin
      if (startEdge) begin
         dataReg   <= 8'd0;
         parAcc    <= 1'b0;
         parBitReg <= 1'b0;
         parErrReg <= 1'b0;
         stop1Reg  <= 1'b1;
      end else if (sampleTick) begin
         case (state)
            ST_DATA: begin
               dataReg[bitIdx] <= bitDecision;
               parAcc          <= parAcc ^ bitDecision;
            end
            ST_PARITY: begin
               parBitReg <= bitDecision;
               parErrReg <= bitDecision != (parAcc ^ frmParOdd);
            end
            ST_STOP1: stop1Reg <= bitDecision;
            default: ;
         endcase
      end
   end

   // Holding register: a pop in the completion cycle frees the slot first
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rxData       <= 8'd0;
         rxValid      <= 1'b0;
         framingError <= 1'b0;
         parityError  <= 1'b0;
         breakDetect  <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (complete) begin
            if (!rxValid || rxReady) begin
               rxData       <= dataReg;
               rxValid      <= 1'b1;
               framingError <= newFraming;
               parityError  <= parErrReg;
               breakDetect  <= newBreak;
            end else begin
               overrun <= 1'b1;
            end
         end else if (rxValid && rxReady) begin
            rxValid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: table of frame formats with hand-computed
// results, plus glitch, break, overrun/pop-alignment and mid-frame reset sequences.
module tb_uart_receiver;
   import uart_pkg::*;

   localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

   logic       clock = 1'b0;
   logic       reset;
   logic       baudRateX16Tick = 1'b0;
   logic       rxd;
   logic [1:0] dataBitsSel;
   logic       parityEnable;
   logic       parityOdd;
   logic       stopBits2;
   logic       rxReady;
   logic [7:0] rxData;
   logic       rxValid;
   logic       framingError;
   logic       parityError;
   logic       breakDetect;
   logic       overrun;

   uart_receiver dut (
      .clock           (clock),
      .reset           (reset),
      .baudRateX16Tick (baudRateX16Tick),
      .rxd             (rxd),
      .dataBitsSel     (dataBitsSel),
      .parityEnable    (parityEnable),
      .parityOdd       (parityOdd),
      .stopBits2       (stopBits2),
      .rxReady         (rxReady),
      .rxData          (rxData),
      .rxValid         (rxValid),
      .framingError    (framingError),
      .parityError     (parityError),
      .breakDetect     (breakDetect),
      .overrun         (overrun)
   );

   always #5 clock = ~clock;

   logic [1:0] tickDiv = 2'd0;
   always @(posedge clock) begin
      tickDiv         <= tickDiv + 2'd1;
      baudRateX16Tick <= (tickDiv == 2'd3);
   end

   typedef struct {
      logic [7:0] data;
      logic [1:0] bits;
      logic       parEn;
      logic       parOdd;
      logic       stop2;
      logic       parBit;
      logic       stopVal;
      logic [7:0] expData;
      logic       expPerr;
      logic       expFerr;
      logic       expBrk;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       brk;
   } got_t;

   got_t gotQ[$];
   int   overrunCnt  = 0;
   int   validCycles = 0;
   int   errors      = 0;
   int   checks      = 0;

   always @(negedge clock) begin
      if (reset && rxValid && rxReady)
         gotQ.push_back('{rxData, parityError, framingError, breakDetect});
      if (overrun) overrunCnt++;
      if (rxValid) validCycles++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sendBit(input logic v);
      rxd = v;
      repeat (BIT_CLKS) @(negedge clock);
   endtask

   task automatic sendFrame(input logic [7:0] d, input int nb, input logic usePar,
                            input logic parBit, input logic stopVal, input int nStop);
      sendBit(1'b0);
      for (int i = 0; i < nb; i++) sendBit(d[i]);
      if (usePar) sendBit(parBit);
      for (int i = 0; i < nStop; i++) sendBit(stopVal);
   endtask

   task automatic setFormat(input logic [1:0] bits, input logic pe, input logic po, input logic s2);
      dataBitsSel  = bits;
      parityEnable = pe;
      parityOdd    = po;
      stopBits2    = s2;
   endtask

   task automatic checkOne(input string tag, input logic [7:0] d, input logic pe,
                           input logic fe, input logic bk);
      check({tag, "_count"}, gotQ.size(), 1);
      if (gotQ.size() >= 1) begin
         check({tag, "_data"},   gotQ[0].data, d);
         check({tag, "_perr"},   gotQ[0].perr, pe);
         check({tag, "_ferr"},   gotQ[0].ferr, fe);
         check({tag, "_break"},  gotQ[0].brk,  bk);
      end
   endtask

   vec_t vecs[9];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h41, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h41, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'h15, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{8'h2A, 2'b01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h2A, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{8'hF5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h15, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{8'h00, 2'b11, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
      vecs[8] = '{8'h80, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0};

      reset   = 1'b0;
      rxd     = 1'b1;
      rxReady = 1'b1;
      setFormat(2'b11, 1'b0, 1'b0, 1'b0);
      repeat (3) @(negedge clock);
      check("rst_rxData",  rxData, 8'h00);
      check("rst_rxValid", rxValid, 1'b0);
      check("rst_flags",   {framingError, parityError, breakDetect, overrun}, 4'b0000);
      check("rst_state",   32'(dut.state), 32'(ST_IDLE));
      reset = 1'b1;
      repeat (BIT_CLKS) @(negedge clock);

      // Format table
      for (int v = 0; v < 9; v++) begin
         setFormat(vecs[v].bits, vecs[v].parEn, vecs[v].parOdd, vecs[v].stop2);
         gotQ.delete();
         validCycles = 0;
         sendFrame(vecs[v].data, int'(vecs[v].bits) + 5, vecs[v].parEn, vecs[v].parBit,
                   vecs[v].stopVal, vecs[v].stop2 ? 2 : 1);
         sendBit(1'b1);
         sendBit(1'b1);
         checkOne($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expPerr,
                  vecs[v].expFerr, vecs[v].expBrk);
         check($sformatf("vec%0d_validCycles", v), validCycles, 1);
      end

      // Short glitch: false start, then a real 0x3C frame
      setFormat(2'b11, 1'b0, 1'b0, 1'b0);
      gotQ.delete();
      rxd = 1'b0;
      repeat (20) @(negedge clock);
      sendBit(1'b1);
      sendBit(1'b1);
      check("glitch_count", gotQ.size(), 0);
      check("glitch_state", 32'(dut.state), 32'(ST_IDLE));
      sendFrame(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1);
      sendBit(1'b1);
      checkOne("after_glitch", 8'h3C, 1'b0, 1'b0, 1'b0);

      // Framing error then a line break
      gotQ.delete();
      sendFrame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1);
      rxd = 1'b0;
      repeat (160) @(negedge clock);
      checkOne("ferr55", 8'h55, 1'b0, 1'b1, 1'b0);
      gotQ.delete();
      sendBit(1'b1);
      sendBit(1'b1);
      for (int i = 0; i < 20; i++) sendBit(1'b0);
      checkOne("break", 8'h00, 1'b0, 1'b1, 1'b1);
      check("break_state", 32'(dut.state), 32'(ST_IDLE));
      sendBit(1'b1);
      sendBit(1'b1);
      check("break_no_more", gotQ.size(), 1);

      // Overrun with consumer stalled, then a pop aligned to completion
      rxReady    = 1'b0;
      gotQ.delete();
      overrunCnt = 0;
      sendFrame(8'h11, 8, 1'b0, 1'b0, 1'b1, 1);
      sendBit(1'b1);
      sendFrame(8'h22, 8, 1'b0, 1'b0, 1'b1, 1);
      sendBit(1'b1);
      check("ovr_rxData",  rxData, 8'h11);
      check("ovr_rxValid", rxValid, 1'b1);
      check("ovr_pulses",  overrunCnt, 1);
      fork
         begin
            sendFrame(8'h33, 8, 1'b0, 1'b0, 1'b1, 1);
            sendBit(1'b1);
         end
         begin
            logic found;
            found = 1'b0;
            for (int i = 0; i < 2000 && !found; i++) begin
               @(negedge clock);
               if (dut.complete) begin
                  found = 1'b1;
                  #1 rxReady = 1'b1;
                  @(posedge clock);
                  #1 rxReady = 1'b0;
               end
            end
            check("pop_aligned_found", found, 1'b1);
         end
      join
      check("pop_rxData",  rxData, 8'h33);
      check("pop_rxValid", rxValid, 1'b1);
      check("pop_no_ovr",  overrunCnt, 1);

      // Reset in the middle of data bit 3 while 0x33 is still held
      gotQ.delete();
      rxd = 1'b0;
      repeat (BIT_CLKS) @(negedge clock);
      rxd = 1'b1;
      repeat (3 * BIT_CLKS + BIT_CLKS / 2) @(negedge clock);
      check("mid_bitIdx", 32'(dut.bitIdx), 3);
      reset = 1'b0;
      #1;
      check("midrst_rxData",  rxData, 8'h00);
      check("midrst_rxValid", rxValid, 1'b0);
      check("midrst_flags",   {framingError, parityError, breakDetect, overrun}, 4'b0000);
      check("midrst_state",   32'(dut.state), 32'(ST_IDLE));
      repeat (5) @(negedge clock);
      reset   = 1'b1;
      rxReady = 1'b1;
      repeat (8) sendBit(1'b1);
      check("midrst_no_partial", gotQ.size(), 0);
      sendFrame(8'h81, 8, 1'b0, 1'b0, 1'b1, 1);
      sendBit(1'b1);
      checkOne("post_reset", 8'h81, 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
